receiver: RTL
=============

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL expose parameter CLKS_PER_TICK, default 27, sys_clk cycles per 16x-oversample tick (50 MHz / 115200 baud / 16).
REQ-002 SHALL expose parameter DATA_BITS, default 8, data bits per frame.
REQ-003 SHALL have port sys_clk  input  1  single system clock; all flops on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port even_odd  input  1  parity select; 0 = even, 1 = odd; sampled at start-bit confirmation.
REQ-006 SHALL have port serial_in  input  1  asynchronous serial line; idles high.
REQ-007 SHALL have port rx_data_out  output  DATA_BITS  last received data word.
REQ-008 SHALL have port rx_valid  output  1  one-cycle pulse when a frame completes.
REQ-009 SHALL have port parity_err  output  1  parity mismatch flag for the last frame.
REQ-010 SHALL have port frame_err  output  1  stop bit sampled low in the last frame.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 Frame format SHALL be: start (0), DATA_BITS data bits LSB first, one parity bit, one stop bit (1).
REQ-013 serial_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-014 A tick counter SHALL count 0..CLKS_PER_TICK-1 and assert tick for one cycle on wrap; it runs freely, but is cleared to 0 on start-edge detection.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-016 IDLE -> START on a synchronized 1->0 transition; the 4-bit oversample counter is cleared.
REQ-017 In START, after 8 ticks (mid start bit): line 0 -> DATA with oversample counter cleared; line 1 -> IDLE (false start, no flags change, no rx_valid).
REQ-018 In DATA, every 16th tick SHALL sample the line into a shift register (shift right, sample enters MSB); after DATA_BITS samples -> PARITY.
REQ-019 In PARITY, the 16th tick SHALL sample the parity bit; expected = XOR of data bits XOR even_odd (latched); mismatch sets internal parity flag.
REQ-020 In STOP, the 16th tick SHALL sample the stop bit; rx_data_out, parity_err, frame_err update and rx_valid pulses the following cycle.
REQ-021 Stop sampled 1 -> IDLE; stop sampled 0 -> frame_err=1 and -> WAIT_IDLE, which returns to IDLE only after the synchronized line reads 1.
REQ-022 Latency: rx_valid SHALL assert within 2 sys_clk cycles of the stop-bit mid-sample tick.
REQ-023 rx_data_out, parity_err and frame_err SHALL hold until the next rx_valid; they are never cleared by a false start.
REQ-024 rx_valid SHALL be high for exactly one sys_clk cycle per completed frame, including errored frames.
REQ-025 A falling edge arriving during DATA/PARITY/STOP SHALL be ignored; back-to-back frames with zero idle time after a valid stop bit SHALL be received without loss.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, counters=0, synchronizer flops=1, rx_data_out=0, rx_valid=0, parity_err=0, frame_err=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_valid; after release the block waits for a new falling edge.

Verification
REQ-028 even_odd=0, send 0xA5 with parity 0, stop 1 -> rx_valid pulse once, rx_data_out=0xA5, parity_err=0, frame_err=0.
REQ-029 even_odd=1, send 0x3C with parity 0 (wrong) -> rx_valid, rx_data_out=0x3C, parity_err=1, frame_err=0.
REQ-030 Send 0x55 with stop bit 0, line held low 20 bit times -> rx_valid, frame_err=1, busy stays high until line returns high, then busy=0.
REQ-031 Low glitch of 4 ticks on idle line -> START then IDLE, no rx_valid, outputs unchanged from prior frame.
REQ-032 Two back-to-back frames 0x01, 0xFF (even parity, no idle gap) -> two rx_valid pulses with 0x01 then 0xFF, no errors.
REQ-033 Assert rst_n low during data bit 3 of a frame -> all outputs 0 immediately; next full frame 0x81 received correctly.

Source files
------------

// File: rtl/receiver.sv
`default_nettype none
// ============================================================================
// Module      : receiver
// Description : 16x-oversampled asynchronous serial receiver with parity and
//               stop-bit checking; start, DATA_BITS data bits LSB first,
//               one parity bit, one stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module receiver #(
    parameter int CLKS_PER_TICK = 27,
    parameter int DATA_BITS     = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 even_odd,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [2:0]           state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 prev_q, prev_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [3:0]           os_q, os_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 eo_q, eo_d;
    logic                 perr_int_q, perr_int_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 valid_q, valid_d;

    logic w_rx;
    logic w_fall;
    logic w_tick;
    logic w_os_last;

    assign w_rx      = sync2_q;
    assign w_fall    = prev_q & ~sync2_q;
    assign w_tick    = (tcnt_q == TICK_LAST);
    assign w_os_last = (os_q == 4'd15);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            tcnt_q     <= '0;
            os_q       <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            eo_q       <= 1'b0;
            perr_int_q <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            tcnt_q     <= tcnt_d;
            os_q       <= os_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            eo_q       <= eo_d;
            perr_int_q <= perr_int_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sync1_d    = serial_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        tcnt_d     = w_tick ? '0 : tcnt_q + TW'(1);
        os_d       = os_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        eo_d       = eo_q;
        perr_int_d = perr_int_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Restart the tick phase so the 8th tick lands mid start bit.
                if (w_fall) begin
                    state_d = S_START;
                    tcnt_d  = '0;
                    os_d    = '0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (os_q == 4'd7) begin
                        if (!w_rx) begin
                            state_d    = S_DATA;
                            os_d       = '0;
                            bit_d      = '0;
                            eo_d       = even_odd;
                            perr_int_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    os_d = os_q + 4'd1;
                    if (w_os_last) begin
                        shift_d = {w_rx, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = S_PARITY;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    os_d = os_q + 4'd1;
                    if (w_os_last) begin
                        perr_int_d = w_rx ^ (^shift_q) ^ eo_q;
                        state_d    = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    os_d = os_q + 4'd1;
                    if (w_os_last) begin
                        data_d  = shift_q;
                        perr_d  = perr_int_q;
                        ferr_d  = ~w_rx;
                        valid_d = 1'b1;
                        state_d = w_rx ? S_IDLE : S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        rx_data_out = data_q;
        rx_valid    = valid_q;
        parity_err  = perr_q;
        frame_err   = ferr_q;
    end

endmodule
`default_nettype wire
